// File: rtl/mem_wb_pipe_if.sv
// Memory-stage-to-writeback bundle: captured instruction fields in, register-file write port and forwarding out.
interface mem_wb_pipe_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 4,
    parameter int CNT_W  = 32
);
    logic              stall;
    logic              flush;
    logic              valid_in;
    logic              RegWrite_in;
    logic [1:0]        ResultSrc_in;
    logic [3:0]        LaneMask_in;
    logic [RA_W-1:0]   Rd_in;
    logic [DATA_W-1:0] ALUResult;
    logic [DATA_W-1:0] MemData;
    logic [DATA_W-1:0] SBoxData;

    logic              valid_out;
    logic              RegWrite_out;
    logic [RA_W-1:0]   Rd_out;
    logic [DATA_W-1:0] Result_out;
    logic [3:0]        LaneEn_out;
    logic              fwd_valid;
    logic [RA_W-1:0]   fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  retire_count;

    modport master (
        output stall, flush, valid_in, RegWrite_in, ResultSrc_in, LaneMask_in,
               Rd_in, ALUResult, MemData, SBoxData,
        input  valid_out, RegWrite_out, Rd_out, Result_out, LaneEn_out,
               fwd_valid, fwd_rd, fwd_data, retire_count
    );

    modport slave (
        input  stall, flush, valid_in, RegWrite_in, ResultSrc_in, LaneMask_in,
               Rd_in, ALUResult, MemData, SBoxData,
        output valid_out, RegWrite_out, Rd_out, Result_out, LaneEn_out,
               fwd_valid, fwd_rd, fwd_data, retire_count
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB register with writeback select, byte-lane enables, forwarding and retired-instruction counter.
// Latency: 1 cycle from inputs to Result_out.
// Backpressure: stall holds every register; flush squashes the incoming instruction and overrides stall.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 4,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         reset,
    mem_wb_pipe_if.slave bus
);
    localparam int LANES = 4;

    logic              valid_q;
    logic              regwrite_q;
    logic [RA_W-1:0]   rd_q;
    logic [DATA_W-1:0] result_q;
    logic [LANES-1:0]  mask_q;
    logic [CNT_W-1:0]  retire_q;

    logic [DATA_W-1:0] sel_result;
    logic [LANES-1:0]  eff_mask;
    logic              wr_en;

    // Merge mode uses the raw mask, so an all-zero mask keeps ALUResult in every lane.
    always_comb begin
        sel_result = bus.ALUResult;
        case (bus.ResultSrc_in)
            2'b00: sel_result = bus.ALUResult;
            2'b01: sel_result = bus.MemData;
            2'b10: sel_result = bus.SBoxData;
            default: begin
                for (int i = 0; i < LANES; i++) begin
                    sel_result[8*i +: 8] = bus.LaneMask_in[i] ? bus.SBoxData[8*i +: 8]
                                                              : bus.ALUResult[8*i +: 8];
                end
            end
        endcase
    end

    assign eff_mask = (bus.LaneMask_in == '0) ? '1 : bus.LaneMask_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            result_q   <= '0;
            mask_q     <= '0;
            retire_q   <= '0;
        end else begin
            // A held instruction leaves on a flush edge even while stalled.
            if (valid_q && (!bus.stall || bus.flush))
                retire_q <= retire_q + CNT_W'(1);
            if (bus.flush) begin
                valid_q    <= 1'b0;
                regwrite_q <= 1'b0;
                rd_q       <= bus.Rd_in;
                result_q   <= sel_result;
                mask_q     <= eff_mask;
            end else if (!bus.stall) begin
                valid_q    <= bus.valid_in;
                regwrite_q <= bus.RegWrite_in;
                rd_q       <= bus.Rd_in;
                result_q   <= sel_result;
                mask_q     <= eff_mask;
            end
        end
    end

    assign wr_en            = valid_q && regwrite_q && (rd_q != '0);
    assign bus.valid_out    = valid_q;
    assign bus.RegWrite_out = wr_en;
    assign bus.Rd_out       = rd_q;
    assign bus.Result_out   = result_q;
    assign bus.LaneEn_out   = wr_en ? mask_q : '0;
    assign bus.fwd_valid    = wr_en;
    assign bus.fwd_rd       = rd_q;
    assign bus.fwd_data     = result_q;
    assign bus.retire_count = retire_q;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: directed scenarios plus random traffic against a lane-level reference model;
// a CNT_W=4 instance shares the stimulus to exercise counter wrap.
module tb_mem_wb_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_wb_pipe_if #(.DATA_W(32), .RA_W(4), .CNT_W(32)) bus ();
    mem_wb_pipe_if #(.DATA_W(32), .RA_W(4), .CNT_W(4))  bus4 ();

    mem_wb_pipe #(.DATA_W(32), .RA_W(4), .CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
    mem_wb_pipe #(.DATA_W(32), .RA_W(4), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

    assign bus4.stall        = bus.stall;
    assign bus4.flush        = bus.flush;
    assign bus4.valid_in     = bus.valid_in;
    assign bus4.RegWrite_in  = bus.RegWrite_in;
    assign bus4.ResultSrc_in = bus.ResultSrc_in;
    assign bus4.LaneMask_in  = bus.LaneMask_in;
    assign bus4.Rd_in        = bus.Rd_in;
    assign bus4.ALUResult    = bus.ALUResult;
    assign bus4.MemData      = bus.MemData;
    assign bus4.SBoxData     = bus.SBoxData;

    int checks = 0;
    int passed = 0;

    // Reference model of what the stage holds.
    logic        m_valid, m_we, m_known;
    logic [3:0]  m_rd, m_mask;
    logic [31:0] m_res;
    int unsigned m_cnt;

    function automatic logic [31:0] ref_sel(input logic [1:0] src, input logic [3:0] lm,
                                            input logic [31:0] alu, input logic [31:0] mem,
                                            input logic [31:0] sb);
        logic [31:0] r;
        r = 32'h0;
        case (src)
            2'd0: r = alu;
            2'd1: r = mem;
            2'd2: r = sb;
            default: begin
                for (int i = 0; i < 4; i++) begin
                    if (((lm >> i) & 4'd1) != 4'd0)
                        r = r | (((sb >> (8 * i)) & 32'hFF) << (8 * i));
                    else
                        r = r | (((alu >> (8 * i)) & 32'hFF) << (8 * i));
                end
            end
        endcase
        return r;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_valid = 0; m_we = 0; m_rd = 0; m_res = 0; m_mask = 0; m_cnt = 0; m_known = 1;
        end else begin
            if (m_valid && (!bus.stall || bus.flush)) m_cnt = m_cnt + 1;
            if (bus.flush) begin
                m_valid = 0; m_we = 0; m_known = 0;
            end else if (!bus.stall) begin
                m_valid = bus.valid_in;
                m_we    = bus.RegWrite_in;
                m_rd    = bus.Rd_in;
                m_res   = ref_sel(bus.ResultSrc_in, bus.LaneMask_in, bus.ALUResult,
                                  bus.MemData, bus.SBoxData);
                m_mask  = (bus.LaneMask_in == 4'd0) ? 4'hF : bus.LaneMask_in;
                m_known = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_all();
        logic wr;
        wr = m_valid && m_we && (m_rd != 4'd0);
        chk("valid_out", 32'(bus.valid_out), 32'(m_valid));
        chk("RegWrite_out", 32'(bus.RegWrite_out), 32'(wr));
        chk("LaneEn_out", 32'(bus.LaneEn_out), wr ? 32'(m_mask) : 32'h0);
        chk("fwd_valid", 32'(bus.fwd_valid), 32'(wr));
        if (m_known) begin
            chk("Rd_out", 32'(bus.Rd_out), 32'(m_rd));
            chk("Result_out", bus.Result_out, m_res);
            chk("fwd_rd", 32'(bus.fwd_rd), 32'(m_rd));
            chk("fwd_data", bus.fwd_data, m_res);
        end
        chk("retire_count", bus.retire_count, m_cnt);
        chk("retire_count4", 32'(bus4.retire_count), m_cnt % 16);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic st, input logic fl, input logic vi, input logic rw,
                         input logic [1:0] src, input logic [3:0] lm, input logic [3:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] sb);
        bus.stall = st; bus.flush = fl; bus.valid_in = vi; bus.RegWrite_in = rw;
        bus.ResultSrc_in = src; bus.LaneMask_in = lm; bus.Rd_in = rd;
        bus.ALUResult = alu; bus.MemData = mem; bus.SBoxData = sb;
    endtask

    task automatic drive_bubble();
        drive(0, 0, 0, 0, 2'd0, 4'd0, 4'd0, $urandom, $urandom, $urandom);
    endtask

    task automatic drive_rand();
        drive($urandom_range(3, 0) == 0, $urandom_range(9, 0) == 0, $urandom_range(3, 0) != 0,
              $urandom_range(1, 0) == 1, 2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)),
              4'($urandom_range(15, 0)), $urandom, $urandom, $urandom);
    endtask

    int unsigned c;

    initial begin
        drive(0, 0, 0, 0, 2'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Memory load to r3, all lanes.
        drive(0, 0, 1, 1, 2'b01, 4'b0000, 4'd3, $urandom, 32'hDEADBEEF, $urandom);
        tick();
        chk("mem_result", bus.Result_out, 32'hDEADBEEF);
        chk("mem_lanes", 32'(bus.LaneEn_out), 32'hF);
        drive_bubble();
        tick();
        chk("first_retire", bus.retire_count, 32'd1);

        // Lane merge.
        drive(0, 0, 1, 1, 2'b11, 4'b0101, 4'd5, 32'h11223344, $urandom, 32'hAABBCCDD);
        tick();
        chk("merge_result", bus.Result_out, 32'h11BB33DD);
        chk("merge_lanes", 32'(bus.LaneEn_out), 32'h5);

        // Register 0 is never written but still retires.
        drive(0, 0, 1, 1, 2'b00, 4'd0, 4'd0, 32'd5, $urandom, $urandom);
        tick();
        chk("r0_we", 32'(bus.RegWrite_out), 32'd0);
        chk("r0_result", bus.Result_out, 32'd5);
        c = m_cnt;
        drive_bubble();
        tick();
        chk("r0_retire", bus.retire_count, c + 1);

        // Hold under stall while inputs change.
        drive(0, 0, 1, 1, 2'b00, 4'd0, 4'd7, 32'h42, $urandom, $urandom);
        tick();
        c = m_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 1, 2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)),
                  4'd9, $urandom, $urandom, $urandom);
            tick();
            chk("stall_rd", 32'(bus.Rd_out), 32'd7);
            chk("stall_result", bus.Result_out, 32'h42);
            chk("stall_count", bus.retire_count, c);
        end
        drive_bubble();
        tick();
        chk("release_count", bus.retire_count, c + 1);

        // Stall and flush together: flush wins, held instruction still retires.
        drive(0, 0, 1, 1, 2'b00, 4'd0, 4'd9, $urandom, $urandom, $urandom);
        tick();
        c = m_cnt;
        drive(1, 1, 1, 1, 2'b00, 4'd0, 4'd10, $urandom, $urandom, $urandom);
        tick();
        chk("flush_valid", 32'(bus.valid_out), 32'd0);
        chk("flush_we", 32'(bus.RegWrite_out), 32'd0);
        chk("flush_count", bus.retire_count, c + 1);
        drive(0, 0, 1, 1, 2'b10, 4'd0, 4'd11, $urandom, $urandom, 32'hCAFEF00D);
        tick();
        chk("post_flush_rd", 32'(bus.Rd_out), 32'd11);
        chk("post_flush_result", bus.Result_out, 32'hCAFEF00D);

        // Counter wrap on the 4-bit instance: 16 retirements after reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(0, 0, 1, $urandom_range(1, 0) == 1, 2'($urandom_range(3, 0)),
                  4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), $urandom, $urandom, $urandom);
            tick();
        end
        chk("wrap_count4", 32'(bus4.retire_count), 32'd0);
        chk("wrap_count32", bus.retire_count, 32'd16);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            drive_rand();
            reset = ($urandom_range(99, 0) == 0);
            tick();
        end
        reset = 1'b0;

        // Reset during a stall clears everything.
        drive(0, 0, 1, 1, 2'b00, 4'd0, 4'd6, 32'h1234, $urandom, $urandom);
        tick();
        drive(1, 0, 1, 1, 2'b00, 4'd0, 4'd8, $urandom, $urandom, $urandom);
        reset = 1'b1;
        tick();
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_rd", 32'(bus.Rd_out), 32'd0);
        chk("rst_result", bus.Result_out, 32'd0);
        chk("rst_lanes", 32'(bus.LaneEn_out), 32'd0);
        chk("rst_count", bus.retire_count, 32'd0);
        reset = 1'b0;
        drive(0, 0, 1, 1, 2'b01, 4'd3, 4'd2, $urandom, 32'h0BADCAFE, $urandom);
        tick();
        chk("rst_reload", bus.Result_out, 32'h0BADCAFE);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
